// File: rtl/switch_debounce4.sv
// Four-channel slide-switch debouncer: 2-flop synchronizer, per-channel IDLE/CHECK FSM.
// Define SWITCH_DEBOUNCE_EDGE_EN to build the sw_rise/sw_fall edge pulses (else tied to 0).
module switch_debounce4 #(
   parameter int unsigned STABLE_CYCLES = 50000,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw_in,
   output logic [3:0] sw_clean,
   output logic [3:0] sw_rise,
   output logic [3:0] sw_fall,
   output logic       changed
);

   typedef enum logic {StIdle, StCheck} state_e;

   localparam logic [CNT_W-1:0] CntTarget = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

   logic [3:0]       sync1_q, sync2_q;
   state_e           state_q [4];
   state_e           state_d [4];
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       clean_q, clean_d;
   logic [3:0]       load;
   logic             changed_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw_in;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      clean_d = clean_q;
      load    = '0;
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            StIdle: begin
               if (sync2_q[i] != clean_q[i]) begin
                  state_d[i] = StCheck;
                  cnt_d[i]   = CntOne;
               end else begin
                  cnt_d[i] = '0;
               end
            end
            StCheck: begin
               if (sync2_q[i] == clean_q[i]) begin
                  // Input fell back before the hold time elapsed: glitch, discard.
                  state_d[i] = StIdle;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CntTarget) begin
                  state_d[i] = StIdle;
                  cnt_d[i]   = '0;
                  clean_d[i] = sync2_q[i];
                  load[i]    = 1'b1;
               end else if (cnt_q[i] != CntMax) begin
                  cnt_d[i] = cnt_q[i] + CntOne;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= '0;
         end
         clean_q   <= '0;
         changed_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         clean_q   <= clean_d;
         changed_q <= |load;
      end
   end

   assign sw_clean = clean_q;
   assign changed  = changed_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
   logic [3:0] rise_q, fall_q;

   // Pulses share the load edge, so they coincide with the new sw_clean value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= load & sync2_q;
         fall_q <= load & ~sync2_q;
      end
   end

   assign sw_rise = rise_q;
   assign sw_fall = fall_q;
`else
   assign sw_rise = '0;
   assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_switch_debounce4.sv
// Directed bench for switch_debounce4 (STABLE_CYCLES=4) with a queue of expected output events.
// Edge-pulse expectations follow SWITCH_DEBOUNCE_EDGE_EN.
module tb_switch_debounce4;

   localparam int unsigned S = 4;
   // Drive after edge c => new sw_clean visible after edge c+1+2+S.
   localparam int Lat = 3 + S;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   localparam bit EdgeEn = 1'b1;
`else
   localparam bit EdgeEn = 1'b0;
`endif

   typedef struct {
      int         cyc;
      logic [3:0] clean;
      logic [3:0] rise;
      logic [3:0] fall;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw_in;
   logic [3:0] sw_clean, sw_rise, sw_fall;
   logic       changed;

   exp_t       sb[$];
   int         cyc;
   int         vectors;
   int         miscompares;
   logic [3:0] exp_clean;
   logic [3:0] settled;

   switch_debounce4 #(
      .STABLE_CYCLES(S),
      .CNT_W        (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sw_in   (sw_in),
      .sw_clean(sw_clean),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall),
      .changed (changed)
   );

   always #5 clk = ~clk;

   task automatic cmp4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic cmp1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [3:0] er, ef;
      logic       ec;
      exp_t       e;
      er = '0;
      ef = '0;
      ec = 1'b0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e         = sb.pop_front();
         exp_clean = e.clean;
         er        = e.rise;
         ef        = e.fall;
         ec        = 1'b1;
      end
      if (!EdgeEn) begin
         er = '0;
         ef = '0;
      end
      cmp4("sw_clean", sw_clean, exp_clean);
      cmp4("sw_rise", sw_rise, er);
      cmp4("sw_fall", sw_fall, ef);
      cmp1("changed", changed, ec);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         check_outputs();
      end
   endtask

   // Settled level change: queue the single expected output event.
   task automatic settle_to(input logic [3:0] nxt);
      exp_t e;
      sw_in   = nxt;
      e.cyc   = cyc + Lat;
      e.clean = nxt;
      e.rise  = nxt & ~settled;
      e.fall  = ~nxt & settled;
      sb.push_back(e);
      settled = nxt;
   endtask

   task automatic reset_now();
      rst = 1'b1;
      #1;
      sb.delete();
      exp_clean = '0;
      settled   = '0;
      cmp4("rst_clean", sw_clean, 4'b0000);
      cmp4("rst_rise", sw_rise, 4'b0000);
      cmp4("rst_fall", sw_fall, 4'b0000);
      cmp1("rst_changed", changed, 1'b0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      sw_in       = '0;
      reset_now();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      tick(3);

      // Single channel rise with exact latency
      settle_to(4'b0001);
      tick(10);

      // Short glitch on C: rejected
      sw_in = 4'b0101;
      tick(3);
      sw_in = 4'b0001;
      tick(8);

      // Boundary: S-cycle pulse rejected, S+1-cycle pulse accepted
      sw_in = 4'b0011;
      tick(S);
      sw_in = 4'b0001;
      tick(8);
      settle_to(4'b0011);
      tick(S + 1);
      settle_to(4'b0001);
      tick(12);

      // Bouncing A settles high: single rise
      settle_to(4'b0000);
      tick(10);
      for (int k = 0; k < 6; k++) begin
         sw_in = (k % 2 == 0) ? 4'b0001 : 4'b0000;
         tick(2);
      end
      settle_to(4'b0001);
      tick(12);

      // All four rise together from 0000
      settle_to(4'b0000);
      tick(10);
      settle_to(4'b1111);
      tick(10);

      // Simultaneous rises and falls on different channels
      settle_to(4'b0110);
      tick(10);
      settle_to(4'b1001);
      tick(10);
      settle_to(4'b1111);
      tick(10);

      // Reset mid-CHECK (counters at 2) abandons the pending fall
      sw_in = 4'b0000;
      tick(4);
      #2;
      reset_now();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      tick(14);

      // Switches held high through reset
      sw_in = 4'b0011;
      reset_now();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      settle_to(4'b0011);
      tick(12);

      vectors++;
      assert (sb.size() === 0) else begin
         miscompares++;
         $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/switch_debounce4.md
SWITCH_DEBOUNCE4 -- requirements
Module: switch_debounce4

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 50000, the number of consecutive synchronized samples a new level must hold before acceptance (1 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 16, the width of each per-channel stability counter.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sw_in  input  4  raw asynchronous slide switches, bit0=A, bit1=B, bit2=C, bit3=D.
REQ-006 SHALL have port sw_clean  output  4  debounced switch levels, which feed the four-input ones-count adder stage.
REQ-007 SHALL have port sw_rise  output  4  one-cycle pulse per channel when sw_clean goes 0->1.
REQ-008 SHALL have port sw_fall  output  4  one-cycle pulse per channel when sw_clean goes 1->0.
REQ-009 SHALL have port changed  output  1  high for one cycle when any sw_clean bit changes.

Function
REQ-010 SHALL pass each sw_in bit through a two-flop synchronizer; only the second flop output (sync) is used downstream.
REQ-011 SHALL run one independent FSM per channel with states IDLE and CHECK, plus a CNT_W-bit counter.
REQ-012 IDLE: if sync equals sw_clean, SHALL stay in IDLE with counter 0; otherwise SHALL go to CHECK with counter 1.
REQ-013 CHECK: if sync equals sw_clean, SHALL return to IDLE with counter 0 (glitch rejected, no output change).
REQ-014 CHECK: if sync differs from sw_clean and counter equals STABLE_CYCLES, SHALL load sw_clean with sync, clear the counter and go to IDLE on that edge.
REQ-015 CHECK: otherwise SHALL increment the counter; the counter SHALL never wrap.
REQ-016 Latency: if sw_in changes before edge k and holds, sw_clean SHALL change at edge k+2+STABLE_CYCLES.
REQ-017 sw_rise, sw_fall and changed SHALL be registered and SHALL be asserted in exactly the cycle in which the new sw_clean value first appears.
REQ-018 Channels SHALL NOT interact; simultaneous changes on several channels SHALL update at the same edge and produce a single one-cycle changed pulse.
REQ-019 A bouncing input SHALL produce at most one sw_clean transition per settled level change.
REQ-020 STABLE_CYCLES SHALL be at least 1 and at most 2^CNT_W-1; other values are unsupported.

Reset
REQ-021 While rst is high, sync flops, sw_clean, counters and all pulse outputs SHALL be 0, and FSMs SHALL be in IDLE, asynchronously.
REQ-022 A switch held high through reset SHALL be treated as a 0->1 change after deassertion: sw_clean rises STABLE_CYCLES+2 edges after the first edge, with a sw_rise pulse.
REQ-023 Reset asserted mid-CHECK SHALL abandon the pending change with no pulse.

Configuration
REQ-024 Macro SWITCH_DEBOUNCE_EDGE_EN: when defined, sw_rise and sw_fall SHALL behave per REQ-007, REQ-008 and REQ-017.
REQ-025 When SWITCH_DEBOUNCE_EDGE_EN is undefined, the ports SHALL remain present, SHALL be driven constant 0000, and no edge-detect logic SHALL be built; sw_clean and changed SHALL be unaffected.

Verification (STABLE_CYCLES=4, macro defined)
REQ-026 sw_in 0000->0001 before edge 10, held -> sw_clean=0001 from edge 16; sw_rise=0001 and changed=1 for that cycle only.
REQ-027 sw_in[2] high for 3 cycles, then low -> sw_clean stays 0000; no pulses.
REQ-028 sw_in[0] toggles every 2 cycles for 12 cycles, then holds 1 from edge 40 -> exactly one sw_rise[0], with sw_clean[0]=1 at edge 46.
REQ-029 sw_in 0000->1111 at once with sw_clean=0000 -> all four bits rise at the same edge; sw_rise=1111; changed is high for one cycle.
REQ-030 sw_clean=1111, then sw_in->0000, and rst pulses when counters=2 -> outputs 0 immediately, no sw_fall; after release with sw_in=0000, all outputs stay 0.
REQ-031 Macro undefined, repeat REQ-026 -> identical sw_clean and changed; sw_rise and sw_fall stay 0000.
